// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// tx and ready come straight from flops, so valid and data have no combinational path to the outputs.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    // state    | meaning
    // S_IDLE   | line at mark, ready high, bit timer held at 0
    // S_START  | start bit (tx = 0)
    // S_DATA   | 8 data bits, LSB first, from the shift register
    // S_PARITY | even/odd parity bit over the latched byte
    // S_STOP   | STOP_BITS stop bits (tx = 1)

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2 || PARITY < 0 || PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_err
        $error("uart_tx: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [TW-1:0]   r_timer;
    logic [7:0]      r_shift;
    logic [2:0]      r_idx;
    logic            r_stop_idx;
    logic            r_par;
    logic            r_tx;
    logic            r_ready;
    logic            w_tx_next;
    logic            w_ready_next;
    logic            w_accept;
    logic            w_bit_end;

    assign w_accept  = valid && (r_state == S_IDLE);
    assign w_bit_end = (r_timer == BIT_LAST);
    assign tx        = r_tx;
    assign ready     = r_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_next = S_START;
            S_START:  if (w_bit_end) w_state_next = S_DATA;
            S_DATA:   if (w_bit_end && r_idx == 3'd7) w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (w_bit_end) w_state_next = S_STOP;
            S_STOP:   if (w_bit_end && (STOP_BITS == 1 || r_stop_idx)) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Output levels are computed for the state being entered so the flops present them from that edge on.
    always_comb begin
        w_tx_next    = 1'b1;
        w_ready_next = (w_state_next == S_IDLE);
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = (r_state == S_DATA && w_bit_end) ? r_shift[1] : r_shift[0];
            S_PARITY: w_tx_next = r_par;
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer    <= '0;
            r_shift    <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
        end else begin
            r_tx    <= w_tx_next;
            r_ready <= w_ready_next;

            if (r_state == S_IDLE || w_bit_end) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            if (w_accept) begin
                r_shift    <= data;
                r_idx      <= '0;
                r_stop_idx <= 1'b0;
                r_par      <= (^data) ^ (PARITY == 2);
            end else begin
                if (r_state == S_DATA && w_bit_end) begin
                    r_shift <= {1'b0, r_shift[7:1]};
                    r_idx   <= r_idx + 3'd1;
                end
                if (r_state == S_STOP && w_bit_end) begin
                    r_stop_idx <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover default timing, short bit periods,
// even/odd parity with two stop bits, handshake behaviour and asynchronous reset.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       v[4];
    logic [7:0] d[4];
    logic       tx_w[4];
    logic       rdy_w[4];
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(434), .PARITY(0), .STOP_BITS(1)) u_def (
        .clk(clk), .reset(reset), .data(d[0]), .valid(v[0]), .ready(rdy_w[0]), .tx(tx_w[0]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_c4 (
        .clk(clk), .reset(reset), .data(d[1]), .valid(v[1]), .ready(rdy_w[1]), .tx(tx_w[1]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) u_even (
        .clk(clk), .reset(reset), .data(d[2]), .valid(v[2]), .ready(rdy_w[2]), .tx(tx_w[2]));
    uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) u_odd (
        .clk(clk), .reset(reset), .data(d[3]), .valid(v[3]), .ready(rdy_w[3]), .tx(tx_w[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Caller has raised valid on the preceding negedge; exp bit i is the level of serial bit i.
    task automatic run_frame(input int sel, input int cpb, input int nbits, input logic [15:0] exp,
                             input bit hold, input logic [7:0] next_d, input string name);
        int last;
        last = nbits * cpb;
        @(posedge clk);
        for (int j = 0; j < last; j++) begin
            @(negedge clk);
            check($sformatf("%s tx c%0d", name, j), 32'(tx_w[sel]), 32'(exp[j / cpb]));
            check($sformatf("%s ready c%0d", name, j), 32'(rdy_w[sel]), 32'd0);
            if (hold) begin
                if (j == 0) d[sel] = 8'hFF;
                if (j == last - 2) d[sel] = next_d;
            end else begin
                if (j == 0) v[sel] = 1'b0;
                if (j == 8) begin
                    v[sel] = 1'b1;
                    d[sel] = 8'hFF;
                end
                if (j == 9) v[sel] = 1'b0;
            end
        end
        @(negedge clk);
        check($sformatf("%s end ready", name), 32'(rdy_w[sel]), 32'd1);
        check($sformatf("%s end tx", name), 32'(tx_w[sel]), 32'd1);
    endtask

    task automatic start_frame(input int sel, input logic [7:0] byte_in);
        @(negedge clk);
        v[sel] = 1'b1;
        d[sel] = byte_in;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        for (int s = 0; s < 4; s++) begin
            v[s] = 1'b0;
            d[s] = 8'h00;
        end

        // Reset pulse mid-cycle with no valid: outputs go to idle immediately.
        #2 reset = 1'b0;
        #1;
        for (int s = 0; s < 4; s++) begin
            check($sformatf("rst tx%0d", s), 32'(tx_w[s]), 32'd1);
            check($sformatf("rst ready%0d", s), 32'(rdy_w[s]), 32'd1);
        end
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || rdy_w[0] !== 1'b1) bad++;
        end
        check("idle 1000 bad cycles", 32'(bad), 32'd0);

        // 0x55 at default timing: alternating 0,1 levels, ready back after 4340 cycles.
        start_frame(0, 8'h55);
        run_frame(0, 434, 10, 16'h02AA, 1'b0, 8'h00, "def55");

        // Extremes at 4 clocks per bit.
        start_frame(1, 8'h00);
        run_frame(1, 4, 10, 16'h0200, 1'b0, 8'h00, "c4_00");
        start_frame(1, 8'hFF);
        run_frame(1, 4, 10, 16'h03FE, 1'b0, 8'h00, "c4_FF");

        // Parity, two stop bits: even parity bit 1, odd parity bit 0 for 0x07.
        start_frame(2, 8'h07);
        run_frame(2, 4, 12, 16'h0E0E, 1'b0, 8'h00, "even07");
        start_frame(3, 8'h07);
        run_frame(3, 4, 12, 16'h0C0E, 1'b0, 8'h00, "odd07");

        // valid held high: A5 then 3C with exactly one mark cycle between frames.
        start_frame(1, 8'hA5);
        run_frame(1, 4, 10, 16'h034A, 1'b1, 8'h3C, "hs_A5");
        run_frame(1, 4, 10, 16'h0278, 1'b0, 8'h00, "hs_3C");
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (tx_w[1] !== 1'b1 || rdy_w[1] !== 1'b1) bad++;
        end
        check("hs idle after", 32'(bad), 32'd0);

        // Reset during bit 3 of 0x00, then a clean 0x81 frame.
        start_frame(1, 8'h00);
        @(posedge clk);
        @(negedge clk);
        v[1] = 1'b0;
        repeat (13) @(negedge clk);
        check("mid tx before rst", 32'(tx_w[1]), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("mid rst tx", 32'(tx_w[1]), 32'd1);
        check("mid rst ready", 32'(rdy_w[1]), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (tx_w[1] !== 1'b1 || rdy_w[1] !== 1'b1) bad++;
        end
        check("post rst idle", 32'(bad), 32'd0);
        start_frame(1, 8'h81);
        run_frame(1, 4, 10, 16'h0302, 1'b0, 8'h00, "c4_81");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
